// File: rtl/pipeline_stall_controller.sv
// Hazard / multi-cycle sequencing controller for the five-stage pipeline.
// Decides per cycle whether PC, IF/ID, ID/EX advance, hold or take a bubble.
module pipeline_stall_controller #(
    parameter int MDU_MAX_CYCLES = 34,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_address_id_i,
    input  logic [4:0]       rs2_address_id_i,
    input  logic             rs1_used_id_i,
    input  logic             rs2_used_id_i,
    input  logic             branch_id_i,
    input  logic             reg_write_ex_i,
    input  logic             mem_to_reg_ex_i,
    input  logic [4:0]       rd_address_ex_i,
    input  logic             mem_to_reg_mem_i,
    input  logic [4:0]       rd_address_mem_i,
    input  logic             mdu_req_ex_i,
    input  logic             mdu_done_i,
    output logic             mdu_start_o,
    output logic             pc_en_o,
    output logic             if_id_en_o,
    output logic             id_ex_en_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_flush_o,
    output logic             mdu_timeout_o,
    output logic [CNT_W-1:0] stall_cycles_o
);
    localparam int BC_W = $clog2(MDU_MAX_CYCLES + 1);

    typedef enum logic {RUN, MDU_BUSY} state_e;

    state_e            state_q, state_d;
    logic [BC_W-1:0]   busy_cnt_q, busy_cnt_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic match_ex, match_mem, hz_load, hz_branch, hz, busy_at_max;

    function automatic logic src_match(input logic used, input logic [4:0] rs,
                                       input logic [4:0] rd);
        return used && (rs == rd) && (rs != 5'd0);
    endfunction

    assign match_ex  = src_match(rs1_used_id_i, rs1_address_id_i, rd_address_ex_i) ||
                       src_match(rs2_used_id_i, rs2_address_id_i, rd_address_ex_i);
    assign match_mem = src_match(rs1_used_id_i, rs1_address_id_i, rd_address_mem_i) ||
                       src_match(rs2_used_id_i, rs2_address_id_i, rd_address_mem_i);

    assign hz_load     = mem_to_reg_ex_i && match_ex;
    assign hz_branch   = branch_id_i && ((reg_write_ex_i && match_ex) ||
                                         (mem_to_reg_mem_i && match_mem));
    assign hz          = hz_load || hz_branch;
    assign busy_at_max = (busy_cnt_q >= BC_W'(MDU_MAX_CYCLES));

    always_comb begin
        state_d        = state_q;
        busy_cnt_d     = busy_cnt_q;
        timeout_d      = timeout_q;
        mdu_start_o    = 1'b0;
        pc_en_o        = 1'b1;
        if_id_en_o     = 1'b1;
        id_ex_en_o     = 1'b1;
        id_ex_flush_o  = 1'b0;
        ex_mem_flush_o = 1'b0;
        case (state_q)
            RUN: begin
                if (mdu_req_ex_i) begin
                    mdu_start_o    = 1'b1;
                    pc_en_o        = 1'b0;
                    if_id_en_o     = 1'b0;
                    id_ex_en_o     = 1'b0;
                    ex_mem_flush_o = 1'b1;
                    state_d        = MDU_BUSY;
                    busy_cnt_d     = '0;
                end else if (hz) begin
                    pc_en_o       = 1'b0;
                    if_id_en_o    = 1'b0;
                    id_ex_flush_o = 1'b1;
                end
            end
            MDU_BUSY: begin
                if (mdu_done_i || busy_at_max) begin
                    // Release cycle: EX drains, ID still obeys the hazard rule.
                    state_d    = RUN;
                    busy_cnt_d = '0;
                    if (!mdu_done_i) timeout_d = 1'b1;
                    if (hz) begin
                        pc_en_o       = 1'b0;
                        if_id_en_o    = 1'b0;
                        id_ex_flush_o = 1'b1;
                    end
                end else begin
                    pc_en_o        = 1'b0;
                    if_id_en_o     = 1'b0;
                    id_ex_en_o     = 1'b0;
                    ex_mem_flush_o = 1'b1;
                    busy_cnt_d     = busy_cnt_q + 1'b1;
                end
            end
        endcase
        // Reset holds the whole pipeline frozen with bubbles loaded.
        if (!reset) begin
            mdu_start_o    = 1'b0;
            pc_en_o        = 1'b0;
            if_id_en_o     = 1'b0;
            id_ex_en_o     = 1'b0;
            id_ex_flush_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            busy_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_cnt_q  <= busy_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mdu_timeout_o  = timeout_q;
    assign stall_cycles_o = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench: two controllers (default watchdog / 4-cycle watchdog with a
// 4-bit stall counter) share stimulus; a behavioural model predicts each cycle.
module tb_pipeline_stall_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] rs1, rs2, rd_ex, rd_mem;
    logic       rs1_used, rs2_used, branch, reg_write_ex, mem_to_reg_ex, mem_to_reg_mem;
    logic       req, done;

    logic [1:0] pc_en, if_id_en, id_ex_en, id_ex_flush, ex_mem_flush, start, timeout;
    logic [31:0] stall0;
    logic [3:0]  stall1;

    always #5 clk = ~clk;

    pipeline_stall_controller #(.MDU_MAX_CYCLES(34), .CNT_W(32)) dut0 (
        .clk(clk), .reset(reset),
        .rs1_address_id_i(rs1), .rs2_address_id_i(rs2),
        .rs1_used_id_i(rs1_used), .rs2_used_id_i(rs2_used), .branch_id_i(branch),
        .reg_write_ex_i(reg_write_ex), .mem_to_reg_ex_i(mem_to_reg_ex),
        .rd_address_ex_i(rd_ex), .mem_to_reg_mem_i(mem_to_reg_mem),
        .rd_address_mem_i(rd_mem), .mdu_req_ex_i(req), .mdu_done_i(done),
        .mdu_start_o(start[0]), .pc_en_o(pc_en[0]), .if_id_en_o(if_id_en[0]),
        .id_ex_en_o(id_ex_en[0]), .id_ex_flush_o(id_ex_flush[0]),
        .ex_mem_flush_o(ex_mem_flush[0]), .mdu_timeout_o(timeout[0]),
        .stall_cycles_o(stall0)
    );

    pipeline_stall_controller #(.MDU_MAX_CYCLES(4), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset),
        .rs1_address_id_i(rs1), .rs2_address_id_i(rs2),
        .rs1_used_id_i(rs1_used), .rs2_used_id_i(rs2_used), .branch_id_i(branch),
        .reg_write_ex_i(reg_write_ex), .mem_to_reg_ex_i(mem_to_reg_ex),
        .rd_address_ex_i(rd_ex), .mem_to_reg_mem_i(mem_to_reg_mem),
        .rd_address_mem_i(rd_mem), .mdu_req_ex_i(req), .mdu_done_i(done),
        .mdu_start_o(start[1]), .pc_en_o(pc_en[1]), .if_id_en_o(if_id_en[1]),
        .id_ex_en_o(id_ex_en[1]), .id_ex_flush_o(id_ex_flush[1]),
        .ex_mem_flush_o(ex_mem_flush[1]), .mdu_timeout_o(timeout[1]),
        .stall_cycles_o(stall1)
    );

    typedef struct packed {
        logic [1:0][5:0]  ctl;   // {pc, if_id, id_ex, id_ex_flush, ex_mem_flush, start}
        logic [1:0]       to;
        logic [1:0][31:0] sc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0, n_pass = 0;
    int   n_start[2], n_flush[2], n_pcz[2];

    // behavioural model state
    int   m_st[2], m_bc[2], m_sc[2];
    logic m_to[2];
    int   m_max[2] = '{34, 4};
    int   m_sat[2] = '{-1, 15};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
    endtask

    function automatic logic mt(input logic used, input logic [4:0] rs, input logic [4:0] rd);
        return used && rs == rd && rs != 5'd0;
    endfunction

    function automatic logic [5:0] mdl_ctl(input int k);
        logic hz;
        logic mex, mmem;
        mex  = mt(rs1_used, rs1, rd_ex) || mt(rs2_used, rs2, rd_ex);
        mmem = mt(rs1_used, rs1, rd_mem) || mt(rs2_used, rs2, rd_mem);
        hz   = (mem_to_reg_ex && mex) ||
               (branch && ((reg_write_ex && mex) || (mem_to_reg_mem && mmem)));
        if (!reset) return 6'b000_110;
        if (m_st[k] == 0) begin
            if (req) return 6'b000_011;
            if (hz)  return 6'b001_100;
            return 6'b111_000;
        end
        if (done || m_bc[k] >= m_max[k]) return hz ? 6'b001_100 : 6'b111_000;
        return 6'b000_010;
    endfunction

    task automatic mdl_seq();
        for (int k = 0; k < 2; k++) begin
            logic [5:0] c;
            c = mdl_ctl(k);
            if (!reset) begin
                m_st[k] = 0; m_bc[k] = 0; m_to[k] = 0; m_sc[k] = 0;
            end else begin
                if (!c[5] && (m_sat[k] < 0 || m_sc[k] < m_sat[k])) m_sc[k]++;
                if (m_st[k] == 0) begin
                    if (req) begin m_st[k] = 1; m_bc[k] = 0; end
                end else if (done) begin
                    m_st[k] = 0; m_bc[k] = 0;
                end else if (m_bc[k] >= m_max[k]) begin
                    m_st[k] = 0; m_bc[k] = 0; m_to[k] = 1'b1;
                end else m_bc[k]++;
            end
        end
    endtask

    task automatic cycle();
        exp_t e, got;
        for (int k = 0; k < 2; k++) begin
            e.ctl[k] = mdl_ctl(k);
            e.to[k]  = m_to[k];
            e.sc[k]  = m_sc[k];
        end
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        for (int k = 0; k < 2; k++)
            got.ctl[k] = {pc_en[k], if_id_en[k], id_ex_en[k], id_ex_flush[k],
                          ex_mem_flush[k], start[k]};
        got.to = timeout;
        got.sc[0] = stall0;
        got.sc[1] = {28'd0, stall1};
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("ctl%0d", k), {26'd0, got.ctl[k]}, {26'd0, e.ctl[k]});
            chk($sformatf("timeout%0d", k), {31'd0, got.to[k]}, {31'd0, e.to[k]});
            chk($sformatf("stall%0d", k), got.sc[k], e.sc[k]);
            n_start[k] += int'(start[k]);
            n_flush[k] += int'(ex_mem_flush[k]);
            n_pcz[k]   += int'(!pc_en[k]);
        end
        @(posedge clk);
        mdl_seq();
        #1;
    endtask

    task automatic idle();
        rs1 = 0; rs2 = 0; rd_ex = 0; rd_mem = 0;
        rs1_used = 0; rs2_used = 0; branch = 0; reg_write_ex = 0;
        mem_to_reg_ex = 0; mem_to_reg_mem = 0; req = 0; done = 0;
    endtask

    task automatic clr_win();
        for (int k = 0; k < 2; k++) begin n_start[k] = 0; n_flush[k] = 0; n_pcz[k] = 0; end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin m_st[k] = 0; m_bc[k] = 0; m_sc[k] = 0; m_to[k] = 0; end
        clr_win();
        idle();
        #1;
        cycle(); cycle();                       // held in reset
        reset = 1'b1;
        cycle();                                // plain run

        // load-use: EX = LW x5, ID = ADD reading x5 via rs2
        mem_to_reg_ex = 1; reg_write_ex = 1; rd_ex = 5; rs2 = 5; rs2_used = 1; rs1 = 1; rs1_used = 1;
        cycle();
        mem_to_reg_ex = 0; reg_write_ex = 0; rd_ex = 0;
        cycle();
        chk("loaduse_stall_cnt", stall0, 1);

        // x0 producer, then unused rs2
        idle(); mem_to_reg_ex = 1; reg_write_ex = 1; rd_ex = 0; rs1 = 0; rs1_used = 1;
        cycle();
        idle(); mem_to_reg_ex = 1; reg_write_ex = 1; rd_ex = 7; rs2 = 7; rs2_used = 0;
        cycle();
        chk("no_stall_x0_unused", stall0, 1);

        // branch after load: 2 stall cycles
        idle(); mem_to_reg_ex = 1; reg_write_ex = 1; rd_ex = 3;
        branch = 1; rs1 = 3; rs1_used = 1; rs2 = 4; rs2_used = 1;
        cycle();
        mem_to_reg_ex = 0; reg_write_ex = 0; rd_ex = 0; mem_to_reg_mem = 1; rd_mem = 3;
        cycle();
        mem_to_reg_mem = 0; rd_mem = 0;
        cycle();
        chk("branch_stall_cnt", stall0, 3);

        // MDU: done 5 cycles after start; ID branch waits on a MEM load through release
        idle(); clr_win();
        branch = 1; rs1 = 9; rs1_used = 1; mem_to_reg_mem = 1; rd_mem = 9; req = 1;
        for (int i = 0; i < 5; i++) cycle();
        done = 1;
        cycle();
        idle();
        cycle();
        chk("mdu_start_pulses", n_start[0], 1);
        chk("mdu_flush_cycles", n_flush[0], 5);
        chk("mdu_stall_delta", stall0, 9);

        // watchdog: done never comes
        idle(); clr_win(); req = 1;
        for (int i = 0; i < 6; i++) cycle();
        req = 0;
        cycle();
        chk("wd4_timeout_set", {31'd0, timeout[1]}, 1);
        chk("wd34_still_busy", {30'd0, timeout[0], pc_en[0]}, 0);
        for (int i = 0; i < 33; i++) cycle();
        chk("wd34_timeout_set", {30'd0, timeout}, 3);

        // fresh request after timeout
        clr_win(); req = 1;
        cycle();
        req = 0;
        cycle();
        done = 1;
        cycle();
        idle();
        cycle();
        chk("fresh_start", n_start[1], 1);
        chk("timeout_sticky", {31'd0, timeout[1]}, 1);
        chk("stall_saturated", {28'd0, stall1}, 15);

        // reset in the middle of an MDU operation
        req = 1;
        cycle();
        cycle();
        #2 reset = 1'b0;
        #1;
        chk("rst_async_ctl", {26'd0, pc_en[0], if_id_en[0], id_ex_en[0], id_ex_flush[0],
                              ex_mem_flush[0], start[0]}, 32'b000_110);
        chk("rst_async_cnt", stall0 | {28'd0, stall1} | {30'd0, timeout}, 0);
        for (int k = 0; k < 2; k++) begin m_st[k] = 0; m_bc[k] = 0; m_sc[k] = 0; m_to[k] = 0; end
        @(posedge clk); #1;
        cycle();
        reset = 1'b1; idle();
        cycle();
        cycle();
        chk("post_reset_no_start", {30'd0, start}, 0);

        if (exp_q.size() != 0) chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
